// File: rtl/peak_scan_engine.sv
// peak_scan_engine: raster scan of a ROWS x COLS image held in a sync-read
// BRAM. Each pixel takes a fixed CONN+2 cycle period: one centre read, one
// slot per neighbour, then one evaluate slot. Up to MAX_PEAKS strict local
// maxima at or above a latched threshold are recorded in raster order.
module peak_scan_engine #(
  parameter int ROWS      = 32,
  parameter int COLS      = 32,
  parameter int PIX_W     = 8,
  parameter int MAX_PEAKS = 8,
  parameter int CONN      = 4,
  localparam int ADDR_W = $clog2(ROWS*COLS),
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int IDX_W  = (MAX_PEAKS > 1) ? $clog2(MAX_PEAKS) : 1,
  localparam int CNT_W  = $clog2(MAX_PEAKS+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  threshold,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [CNT_W-1:0]  peak_num,
  output logic              overflow,
  input  logic [IDX_W-1:0]  res_idx,
  output logic [ROW_W-1:0]  res_row,
  output logic [COL_W-1:0]  res_col,
  output logic [PIX_W-1:0]  res_val,
  output logic [31:0]       scan_cycles
);

  localparam int P      = CONN + 2;
  localparam int SLOT_W = $clog2(P);

  if ((CONN != 4) && (CONN != 8)) begin : g_bad_conn
    $error("peak_scan_engine: CONN must be 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t              state, state_nx;
  logic [SLOT_W-1:0]   slot;
  logic [ROW_W-1:0]    row, nrow;
  logic [COL_W-1:0]    col, ncol;
  logic [PIX_W-1:0]    thr, centre;
  logic                gt_all;   // centre beat every in-bounds neighbour so far
  logic                rd_vld;   // mem_rd_data carries a real read this cycle
  logic                up, dn, lf, rt, inb;
  logic                is_rd, is_eval, last_px, is_peak, wr_en;

  logic [ROW_W-1:0]    pk_row [MAX_PEAKS];
  logic [COL_W-1:0]    pk_col [MAX_PEAKS];
  logic [PIX_W-1:0]    pk_val [MAX_PEAKS];

  // Slot decode: which neighbour this slot addresses and whether it exists.
  always_comb begin
    int sl;
    sl      = int'(slot);
    up      = 1'b0;
    dn      = 1'b0;
    lf      = 1'b0;
    rt      = 1'b0;
    is_rd   = (sl <= CONN);
    is_eval = (sl == P-1);
    if (sl >= 1 && sl <= CONN) begin
      // order N,S,W,E then NW,NE,SW,SE
      up = (sl == 1) || (sl == 5) || (sl == 6);
      dn = (sl == 2) || (sl == 7) || (sl == 8);
      lf = (sl == 3) || (sl == 5) || (sl == 7);
      rt = (sl == 4) || (sl == 6) || (sl == 8);
    end
    inb  = !(up && row == '0) && !(dn && row == ROW_W'(ROWS-1)) &&
           !(lf && col == '0) && !(rt && col == COL_W'(COLS-1));
    nrow = row - ROW_W'(up) + ROW_W'(dn);
    ncol = col - COL_W'(lf) + COL_W'(rt);
    mem_rd_en   = (state == SCAN) && is_rd && inb;
    mem_rd_addr = mem_rd_en ? (ADDR_W'(nrow) * ADDR_W'(COLS) + ADDR_W'(ncol)) : '0;
  end

  // Peak decision in the evaluate slot; last neighbour is still on the bus.
  always_comb begin
    last_px = (row == ROW_W'(ROWS-1)) && (col == COL_W'(COLS-1));
    is_peak = gt_all && (!rd_vld || (centre > mem_rd_data)) && (centre >= thr);
    wr_en   = (state == SCAN) && is_eval && is_peak && (peak_num < CNT_W'(MAX_PEAKS));
  end

  // FSM next state and status outputs.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (is_eval && last_px) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy = (state == SCAN);
    done = (state == FIN);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Scan datapath: slot/pixel counters, compare accumulation, result counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot        <= '0;
      row         <= '0;
      col         <= '0;
      thr         <= '0;
      centre      <= '0;
      gt_all      <= 1'b0;
      rd_vld      <= 1'b0;
      peak_num    <= '0;
      overflow    <= 1'b0;
      scan_cycles <= '0;
    end else begin
      rd_vld <= mem_rd_en;
      case (state)
        IDLE: if (start) begin
          thr         <= threshold;
          peak_num    <= '0;
          overflow    <= 1'b0;
          scan_cycles <= '0;
          slot        <= '0;
          row         <= '0;
          col         <= '0;
        end
        SCAN: begin
          scan_cycles <= scan_cycles + 32'd1;
          if (slot == SLOT_W'(1)) begin
            centre <= mem_rd_data;
            gt_all <= 1'b1;
          end else if (slot != '0 && !is_eval && rd_vld && !(centre > mem_rd_data)) begin
            gt_all <= 1'b0;
          end
          if (is_eval) begin
            slot <= '0;
            if (is_peak) begin
              if (peak_num < CNT_W'(MAX_PEAKS)) peak_num <= peak_num + 1'b1;
              else                              overflow <= 1'b1;
            end
            if (col == COL_W'(COLS-1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end else begin
            slot <= slot + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result buffer write; stale entries are masked by peak_num on read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pk_row[peak_num[IDX_W-1:0]] <= row;
      pk_col[peak_num[IDX_W-1:0]] <= col;
      pk_val[peak_num[IDX_W-1:0]] <= centre;
    end
  end

  // Registered result read port; indices past peak_num read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_row <= '0;
      res_col <= '0;
      res_val <= '0;
    end else if (CNT_W'(res_idx) < peak_num) begin
      res_row <= pk_row[res_idx];
      res_col <= pk_col[res_idx];
      res_val <= pk_val[res_idx];
    end else begin
      res_row <= '0;
      res_col <= '0;
      res_val <= '0;
    end
  end

endmodule

// File: tb/tb_peak_scan_engine.sv
// Directed bench for peak_scan_engine: CONN=4 main instance with an
// address/enable monitor, plus a CONN=8 instance for the connectivity case.
module tb_peak_scan_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, start8 = 1'b0;
  logic [7:0] threshold = 8'd0;
  logic [7:0] img [0:1023];

  logic       busy, done, mem_rd_en, overflow;
  logic [9:0] mem_rd_addr;
  logic [7:0] rdata, res_val;
  logic [3:0] peak_num;
  logic [2:0] res_idx = 3'd0;
  logic [4:0] res_row, res_col;
  logic [31:0] scan_cycles;

  logic       busy8, done8, rd_en8, overflow8;
  logic [9:0] addr8;
  logic [7:0] rdata8, res_val8;
  logic [3:0] peak_num8;
  logic [2:0] res_idx8 = 3'd0;
  logic [4:0] res_row8, res_col8;
  logic [31:0] scan_cycles8;

  peak_scan_engine #(.CONN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(rdata), .peak_num(peak_num), .overflow(overflow),
    .res_idx(res_idx), .res_row(res_row), .res_col(res_col), .res_val(res_val),
    .scan_cycles(scan_cycles));

  peak_scan_engine #(.CONN(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .threshold(threshold),
    .busy(busy8), .done(done8), .mem_rd_en(rd_en8), .mem_rd_addr(addr8),
    .mem_rd_data(rdata8), .peak_num(peak_num8), .overflow(overflow8),
    .res_idx(res_idx8), .res_row(res_row8), .res_col(res_col8), .res_val(res_val8),
    .scan_cycles(scan_cycles8));

  // BRAM model: one cycle read latency per port
  always @(posedge clk) begin
    if (mem_rd_en) rdata  <= img[mem_rd_addr];
    if (rd_en8)    rdata8 <= img[addr8];
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: independent model of the slot schedule for the CONN=4 instance
  int bcnt = 0, last_len = 0, done_cnt = 0, mon_err = 0;
  int mp, ms, mr, mc, ea;
  bit ee;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) begin
      mp = bcnt / 6; ms = bcnt % 6; mr = mp / 32; mc = mp % 32;
      ee = 1'b0; ea = 0;
      case (ms)
        0: begin ee = 1'b1;     ea = mr*32 + mc;       end
        1: begin ee = (mr > 0);  ea = (mr-1)*32 + mc;   end
        2: begin ee = (mr < 31); ea = (mr+1)*32 + mc;   end
        3: begin ee = (mc > 0);  ea = mr*32 + mc - 1;   end
        4: begin ee = (mc < 31); ea = mr*32 + mc + 1;   end
        default: ee = 1'b0;
      endcase
      if (mem_rd_en !== ee) mon_err++;
      else if (ee && int'(mem_rd_addr) != ea) mon_err++;
      bcnt++;
    end else begin
      if (bcnt != 0) last_len = bcnt;
      bcnt = 0;
      if (mem_rd_en !== 1'b0) mon_err++;
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 8'd0;
  endtask

  task automatic chk_entry(input string tag, input int idx, input int r, input int c, input int v);
    @(negedge clk) res_idx = 3'(idx);
    @(negedge clk);
    chk({tag, "_row"}, res_row, r);
    chk({tag, "_col"}, res_col, c);
    chk({tag, "_val"}, res_val, v);
  endtask

  // Start a scan, optionally poke start mid-scan, wait for done (bounded)
  task automatic run_scan(input logic [7:0] thr, input int inj, input bit both);
    int d0, n;
    d0 = done_cnt;
    @(negedge clk); threshold = thr; start = 1'b1; start8 = both;
    @(negedge clk); start = 1'b0; start8 = 1'b0; threshold = 8'd0;
    chk("busy_rise", busy, 1);
    n = 0;
    while (!done && n < 8000) begin
      start = (n == inj);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    @(negedge clk); @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_len", last_len, 6144);
    chk("oob_mon", mon_err, 0);
  endtask

  initial begin
    int n;
    clear_img();
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_peak_num", peak_num, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cycles", scan_cycles, 0);
    chk("rst_res", {res_row, res_col, res_val}, 0);

    // single peak, with an ignored start at busy cycle 100
    img[5*32+7] = 8'd200;
    run_scan(8'd1, 100, 1'b0);
    chk("single_num", peak_num, 1);
    chk("single_ovf", overflow, 0);
    chk("single_cycles", scan_cycles, 6144);
    chk_entry("single_e0", 0, 5, 7, 200);
    chk_entry("single_e1", 1, 0, 0, 0);

    // image corners
    clear_img(); img[0] = 8'd9; img[1023] = 8'd9;
    run_scan(8'd1, -1, 1'b0);
    chk("edge_num", peak_num, 2);
    chk_entry("edge_e0", 0, 0, 0, 9);
    chk_entry("edge_e1", 1, 31, 31, 9);

    // diagonal neighbours: two peaks with CONN=4, one with CONN=8
    clear_img(); img[10*32+10] = 8'd50; img[11*32+11] = 8'd60;
    run_scan(8'd1, -1, 1'b1);
    chk("conn4_num", peak_num, 2);
    chk_entry("conn4_e0", 0, 10, 10, 50);
    n = 0;
    while (!done8 && n < 12000) begin @(negedge clk); n++; end
    chk("conn8_done", done8, 1);
    @(negedge clk);
    chk("conn8_num", peak_num8, 1);
    chk("conn8_cycles", scan_cycles8, 10240);
    res_idx8 = 3'd0;
    @(negedge clk); @(negedge clk);
    chk("conn8_e0", {res_row8, res_col8, res_val8}, {5'd11, 5'd11, 8'd60});

    // plateau plus a 20 below threshold 21, then threshold 20
    clear_img(); img[3*32+3] = 8'd100; img[3*32+4] = 8'd100; img[20*32+20] = 8'd20;
    run_scan(8'd21, -1, 1'b0);
    chk("thr21_num", peak_num, 0);
    chk_entry("thr21_e0", 0, 0, 0, 0);
    run_scan(8'd20, -1, 1'b0);
    chk("thr20_num", peak_num, 1);
    chk_entry("thr20_e0", 0, 20, 20, 20);

    // overflow: ten isolated peaks, values 1..10 in raster order
    clear_img();
    for (int i = 0; i < 10; i++) img[(2*i)*32+3] = 8'(i+1);
    run_scan(8'd1, -1, 1'b0);
    chk("ovf_num", peak_num, 8);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 8; i++) chk_entry($sformatf("ovf_e%0d", i), i, 2*i, 3, i+1);

    // blank scan clears overflow and count
    clear_img();
    run_scan(8'd1, -1, 1'b0);
    chk("blank_num", peak_num, 0);
    chk("blank_ovf", overflow, 0);

    // reset mid-scan
    img[0] = 8'd9; img[1023] = 8'd9;
    @(negedge clk); threshold = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (1000) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    chk("abort_pre_num", peak_num, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", mem_rd_en, 0);
    chk("abort_num", peak_num, 0);
    rst = 1'b0;
    n = done_cnt;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - n, 0);

    // fresh scan after the abort
    run_scan(8'd1, -1, 1'b0);
    chk("fresh_num", peak_num, 2);
    chk("fresh_cycles", scan_cycles, 6144);
    chk_entry("fresh_e0", 0, 0, 0, 9);
    chk_entry("fresh_e1", 1, 31, 31, 9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/peak_scan_engine.md
Name: peak_scan_engine

Overview:
- Parametrised successor to the current fixed 32x32, 8-bit, 4-peak detection core.
- Scans a ROWS x COLS image held in a synchronous-read BRAM and records up to MAX_PEAKS local maxima in raster order.
- Adds a runtime threshold, 4- or 8-connectivity, overflow reporting and a scan cycle counter.
- Sits in the core_clk domain between the image BRAM read port and the control/display logic. All CDC handling stays outside this block.

Parameters:
- ROWS, 32, image height.
- COLS, 32, image width.
- PIX_W, 8, pixel bit width.
- MAX_PEAKS, 8, result buffer depth (>=1).
- CONN, 4, neighbourhood: 4 or 8. Any other value is an elaboration error.
- Derived localparams:
  - ADDR_W = clog2(ROWS*COLS)
  - ROW_W = clog2(ROWS)
  - COL_W = clog2(COLS)
  - IDX_W = clog2(MAX_PEAKS) (min 1)
  - CNT_W = clog2(MAX_PEAKS+1)

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  scan request, sampled only in IDLE.
- threshold  in  PIX_W  minimum peak value; sampled at start acceptance.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse at scan completion.
- mem_rd_en  out  1  BRAM read enable.
- mem_rd_addr  out  ADDR_W  BRAM address = row*COLS+col.
- mem_rd_data  in  PIX_W  BRAM data, valid exactly 1 cycle after mem_rd_en.
- peak_num  out  CNT_W  peaks stored, saturates at MAX_PEAKS.
- overflow  out  1  sticky: a peak was found while the buffer was full.
- res_idx  in  IDX_W  result read index.
- res_row  out  ROW_W  row of entry res_idx.
- res_col  out  COL_W  column of entry res_idx.
- res_val  out  PIX_W  value of entry res_idx.
- scan_cycles  out  32  busy-cycle count of the last or current scan.

Behaviour:
- Reset (sync, active-high): state IDLE. All outputs 0: busy, done, mem_rd_en, mem_rd_addr, peak_num, overflow, scan_cycles, res_*. rst overrides start in the same cycle.
- A reset mid-scan aborts on the next edge; partial results are discarded.
- FSM states: IDLE -> SCAN -> FIN -> IDLE.
- IDLE:
  - start=1 on an edge: latch threshold; clear peak_num, overflow and scan_cycles; pixel (0,0), slot 0; go to SCAN.
  - busy rises the following cycle.
- SCAN, per pixel a fixed period of P = CONN+2 cycles:
  - Slot 0 reads the centre.
  - Slots 1..CONN read neighbours in order N,S,W,E (CONN=8 adds NW,NE,SW,SE).
  - Slot CONN+1 evaluates using the data returned from slot CONN.
- Out-of-bounds neighbour: that slot issues mem_rd_en=0 (mem_rd_addr don't-care) and the neighbour is ignored in the compare.
- Peak condition: centre >= latched threshold, and centre strictly > every in-bounds neighbour. Equal neighbours mean no peak, so plateaus report nothing.
- Peak found:
  - peak_num < MAX_PEAKS: write {row,col,val} to entry peak_num, then increment.
  - Otherwise: set overflow; buffer unchanged.
- Pixel advance: col wraps COLS-1 -> 0 with row+1. After pixel (ROWS-1,COLS-1) is evaluated, go to FIN.
- busy timing: high for exactly ROWS*COLS*P consecutive cycles. scan_cycles increments each busy cycle.
- FIN: busy=0, done=1 for one cycle, then IDLE. A start asserted during FIN is ignored; start is accepted from the next IDLE cycle.
- start while busy: ignored. threshold changes during a scan have no effect.
- Result read:
  - res_row/col/val are registered, 1-cycle latency from res_idx.
  - res_idx >= peak_num returns all zeros.
  - Reads are allowed during a scan and return the entries committed so far.
- peak_num, overflow and the results hold after done until the next accepted start or reset.
- Width rules: compares are unsigned PIX_W. scan_cycles wraps at 2^32 (unreachable for sane parameters).

Test Plan:
- Defaults; all zeros except (5,7)=200; threshold=1 -> busy exactly 6144 cycles; one done pulse; peak_num=1; res_idx=0 gives (5,7,200); res_idx=1 gives 0,0,0; scan_cycles=6144.
- Edges: (0,0)=9, (31,31)=9 -> peak_num=2, entry0=(0,0,9), entry1=(31,31,9). No mem_rd_en in out-of-bounds slots (checked by monitor).
- Connectivity: (10,10)=50, (11,11)=60 -> CONN=4 gives peak_num=2; CONN=8 gives peak_num=1, entry0=(11,11,60).
- Plateau/threshold: (3,3)=(3,4)=100 -> peak_num=0. Single pixel 20 with threshold=21 -> peak_num=0; threshold=20 -> peak_num=1.
- Overflow: 10 isolated peaks of value 1..10 in raster order, MAX_PEAKS=8 -> peak_num=8, overflow=1, entries hold values 1..8. Next scan on a blank image clears overflow and peak_num.
- Control: start pulse at busy cycle 100 -> ignored, length unchanged. rst at busy cycle 1000 -> next cycle busy=0, mem_rd_en=0, peak_num=0, no done pulse. A fresh start then yields correct results.
